hp_vpu_dispatch: RTL and testbench

Decode/dispatch stage directly downstream of the VPU instruction queue. It pops one entry at a time into a holding register and extracts the RVV register fields. A vector-register busy scoreboard blocks RAW and WAW hazards, and clean instructions issue to the execution lanes over a valid/ready handshake. Non-OP-V encodings are dropped and reported on a one-cycle error strobe.

---
 rtl/hp_vpu_dispatch.sv | 138 +++++++++++++
 tb/tb_hp_vpu_dispatch.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_vpu_dispatch.sv
// VPU decode/dispatch: holds one queue entry, blocks RAW/WAW on a vreg busy scoreboard, issues over valid/ready.
// Optional macro HP_VPU_DISPATCH_WB_BYPASS_EN lets a same-cycle writeback release clear the hazard.
module hp_vpu_dispatch #(
    parameter int unsigned ID_W = 4,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            iq_empty_i,
    input  logic [31:0]     iq_instr_i,
    input  logic [ID_W-1:0] iq_id_i,
    input  logic [31:0]     iq_rs1_i,
    input  logic [31:0]     iq_rs2_i,
    output logic            iq_pop_o,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [31:0]     issue_instr_o,
    output logic [ID_W-1:0] issue_id_o,
    output logic [31:0]     issue_rs1_o,
    output logic [31:0]     issue_rs2_o,
    output logic [4:0]      issue_vd_o,
    output logic [4:0]      issue_vs1_o,
    output logic [4:0]      issue_vs2_o,
    output logic [2:0]      issue_funct3_o,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_vd_i,
    output logic            err_valid_o,
    output logic [ID_W-1:0] err_id_o,
    output logic            busy_o
);

    localparam int unsigned REG_W   = 5;
    localparam logic [6:0]  OPC_OPV = 7'h57;
    localparam logic [2:0]  F3_CFG  = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t            state_q;
    logic [31:0]       instr_q;
    logic [31:0]       rs1_q;
    logic [31:0]       rs2_q;
    logic [ID_W-1:0]   id_q;
    logic [NREG-1:0]   sb_q;

    logic [REG_W-1:0]  vd;
    logic [REG_W-1:0]  vs1;
    logic [REG_W-1:0]  vs2;
    logic [2:0]        funct3;
    logic              is_cfg;
    logic              use_vs1;
    logic              hazard;
    logic              issue_fire;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   rd_mask;
    logic [NREG-1:0]   sb_chk;

    assign vd      = instr_q[11:7];
    assign vs1     = instr_q[19:15];
    assign vs2     = instr_q[24:20];
    assign funct3  = instr_q[14:12];
    assign is_cfg  = (funct3 == F3_CFG);
    assign use_vs1 = (funct3 <= 3'b010);

    // Writeback release mask and the set of registers the held instruction touches
    always_comb begin
        clr_mask = '0;
        rd_mask  = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            clr_mask[i] = wb_valid_i && (wb_vd_i == REG_W'(i));
            rd_mask[i]  = (!is_cfg && ((vs2 == REG_W'(i)) || (vd == REG_W'(i))))
                        || (use_vs1 && (vs1 == REG_W'(i)));
        end
    end

`ifdef HP_VPU_DISPATCH_WB_BYPASS_EN
    assign sb_chk = sb_q & ~clr_mask;
`else
    assign sb_chk = sb_q;
`endif

    assign hazard        = |(sb_chk & rd_mask);
    assign issue_valid_o = (state_q == ST_HELD) && !hazard;
    assign issue_fire    = issue_valid_o && issue_ready_i;
    assign iq_pop_o      = !iq_empty_i && !flush_i
                         && ((state_q == ST_EMPTY) || (state_q == ST_ERR) || issue_fire);

    // Destination marked busy when a vreg-writing instruction leaves
    always_comb begin
        set_mask = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            set_mask[i] = issue_fire && !is_cfg && (vd == REG_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            id_q    <= '0;
            sb_q    <= '0;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            sb_q    <= '0;
        end else begin
            sb_q <= (sb_q & ~clr_mask) | set_mask;
            if (iq_pop_o) begin
                instr_q <= iq_instr_i;
                rs1_q   <= iq_rs1_i;
                rs2_q   <= iq_rs2_i;
                id_q    <= iq_id_i;
                state_q <= (iq_instr_i[6:0] == OPC_OPV) ? ST_HELD : ST_ERR;
            end else if (issue_fire || (state_q == ST_ERR)) begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign issue_instr_o  = instr_q;
    assign issue_id_o     = id_q;
    assign issue_rs1_o    = rs1_q;
    assign issue_rs2_o    = rs2_q;
    assign issue_vd_o     = vd;
    assign issue_vs1_o    = vs1;
    assign issue_vs2_o    = vs2;
    assign issue_funct3_o = funct3;
    assign err_valid_o    = (state_q == ST_ERR);
    assign err_id_o       = id_q;
    assign busy_o         = (state_q != ST_EMPTY) || (|sb_q);

endmodule

// File: tb/tb_hp_vpu_dispatch.sv
// Bench for hp_vpu_dispatch: table vectors, directed hazard/flush sequences, random traffic vs a queue/set model.
module tb_hp_vpu_dispatch;

    localparam int unsigned ID_W = 4;
    localparam int unsigned NREG = 32;
`ifdef HP_VPU_DISPATCH_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_i;
    logic            iq_empty_i;
    logic [31:0]     iq_instr_i;
    logic [ID_W-1:0] iq_id_i;
    logic [31:0]     iq_rs1_i;
    logic [31:0]     iq_rs2_i;
    logic            iq_pop_o;
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic [31:0]     issue_instr_o;
    logic [ID_W-1:0] issue_id_o;
    logic [31:0]     issue_rs1_o;
    logic [31:0]     issue_rs2_o;
    logic [4:0]      issue_vd_o;
    logic [4:0]      issue_vs1_o;
    logic [4:0]      issue_vs2_o;
    logic [2:0]      issue_funct3_o;
    logic            wb_valid_i;
    logic [4:0]      wb_vd_i;
    logic            err_valid_o;
    logic [ID_W-1:0] err_id_o;
    logic            busy_o;

    hp_vpu_dispatch #(.ID_W(ID_W), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .iq_empty_i(iq_empty_i), .iq_instr_i(iq_instr_i), .iq_id_i(iq_id_i),
        .iq_rs1_i(iq_rs1_i), .iq_rs2_i(iq_rs2_i), .iq_pop_o(iq_pop_o),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_id_o(issue_id_o),
        .issue_rs1_o(issue_rs1_o), .issue_rs2_o(issue_rs2_o),
        .issue_vd_o(issue_vd_o), .issue_vs1_o(issue_vs1_o), .issue_vs2_o(issue_vs2_o),
        .issue_funct3_o(issue_funct3_o), .wb_valid_i(wb_valid_i), .wb_vd_i(wb_vd_i),
        .err_valid_o(err_valid_o), .err_id_o(err_id_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     instr;
        logic [ID_W-1:0] id;
        logic [31:0]     rs1;
        logic [31:0]     rs2;
    } entry_t;

    typedef struct {
        logic [31:0]     instr;
        logic [ID_W-1:0] id;
        bit              is_err;
        logic [4:0]      vd;
        logic [4:0]      vs1;
        logic [4:0]      vs2;
        logic [2:0]      f3;
        bit              busy_after;
    } vec_t;

    entry_t q[$];
    bit     m_held, m_err, n_held, n_err, dut_pop;
    entry_t m_e, n_e;
    bit     m_busy[NREG];
    bit     n_busy[NREG];
    int     vectors = 0;
    int     miscompares = 0;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] vd,
                                       input logic [4:0] vs1, input logic [4:0] vs2);
        return {6'b000000, 1'b1, vs2, vs1, f3, vd, 7'h57};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [ID_W-1:0] id);
        entry_t e;
        e.instr = instr;
        e.id    = id;
        e.rs1   = $urandom;
        e.rs2   = $urandom;
        q.push_back(e);
    endtask

    // Drive queue head, compare DUT against model, compute model's next state
    task automatic eval();
        bit busy_eff[NREG];
        bit hz, exp_valid, exp_pop, fire, any;
        logic [2:0] f3;
        int vd, vs1, vs2;
        iq_empty_i = (q.size() == 0);
        if (q.size() != 0) begin
            iq_instr_i = q[0].instr;
            iq_id_i    = q[0].id;
            iq_rs1_i   = q[0].rs1;
            iq_rs2_i   = q[0].rs2;
        end
        #1;
        busy_eff = m_busy;
        if (BYPASS && wb_valid_i) busy_eff[wb_vd_i] = 1'b0;
        f3  = m_e.instr[14:12];
        vd  = int'(m_e.instr[11:7]);
        vs1 = int'(m_e.instr[19:15]);
        vs2 = int'(m_e.instr[24:20]);
        hz = 1'b0;
        if (f3 != 3'd7) hz = busy_eff[vs2] || busy_eff[vd];
        if (f3 <= 3'd2) hz = hz || busy_eff[vs1];
        exp_valid = m_held && !hz;
        exp_pop   = !iq_empty_i && !flush_i && (!m_held || (exp_valid && issue_ready_i));
        any = m_held || m_err;
        foreach (m_busy[i]) any = any || m_busy[i];
        chk("pop", 32'(iq_pop_o), 32'(exp_pop));
        chk("issue_valid", 32'(issue_valid_o), 32'(exp_valid));
        chk("err_valid", 32'(err_valid_o), 32'(m_err));
        chk("busy", 32'(busy_o), 32'(any));
        if (exp_valid) begin
            chk("instr", issue_instr_o, m_e.instr);
            chk("id", 32'(issue_id_o), 32'(m_e.id));
            chk("rs1", issue_rs1_o, m_e.rs1);
            chk("rs2", issue_rs2_o, m_e.rs2);
            chk("vd", 32'(issue_vd_o), 32'(vd));
            chk("vs1", 32'(issue_vs1_o), 32'(vs1));
            chk("vs2", 32'(issue_vs2_o), 32'(vs2));
            chk("funct3", 32'(issue_funct3_o), 32'(f3));
        end
        if (m_err) chk("err_id", 32'(err_id_o), 32'(m_e.id));
        dut_pop = iq_pop_o;
        fire   = exp_valid && issue_ready_i;
        n_busy = m_busy;
        n_e    = m_e;
        n_held = m_held;
        n_err  = m_err;
        if (flush_i) begin
            n_held = 1'b0;
            n_err  = 1'b0;
            foreach (n_busy[i]) n_busy[i] = 1'b0;
        end else begin
            if (wb_valid_i) n_busy[wb_vd_i] = 1'b0;
            if (fire && f3 != 3'd7) n_busy[vd] = 1'b1;
            if (exp_pop) begin
                n_e    = q[0];
                n_held = (q[0].instr[6:0] == 7'h57);
                n_err  = !n_held;
            end else if (fire || m_err) begin
                n_held = 1'b0;
                n_err  = 1'b0;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        m_busy = n_busy;
        m_e    = n_e;
        m_held = n_held;
        m_err  = n_err;
        if (dut_pop && q.size() != 0) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            eval();
            adv();
        end
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        eval();
        adv();
        flush_i = 1'b0;
    endtask

    initial begin
        vec_t tbl[7];
        logic [31:0] ri;
        int r;

        tbl[0] = '{mk(3'd0, 5'd3, 5'd1, 5'd2),     4'd5,  1'b0, 5'd3,  5'd1,  5'd2,  3'd0, 1'b1};
        tbl[1] = '{mk(3'd3, 5'd10, 5'd7, 5'd20),   4'd6,  1'b0, 5'd10, 5'd7,  5'd20, 3'd3, 1'b1};
        tbl[2] = '{mk(3'd7, 5'd5, 5'd10, 5'd0),    4'd7,  1'b0, 5'd5,  5'd10, 5'd0,  3'd7, 1'b0};
        tbl[3] = '{32'h00000013,                   4'd9,  1'b1, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0};
        tbl[4] = '{32'h00000057,                   4'd15, 1'b0, 5'd0,  5'd0,  5'd0,  3'd0, 1'b1};
        tbl[5] = '{32'hFFFFFFFF,                   4'd2,  1'b1, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0};
        tbl[6] = '{mk(3'd6, 5'd31, 5'd31, 5'd31),  4'd1,  1'b0, 5'd31, 5'd31, 5'd31, 3'd6, 1'b1};

        m_e = '{default: '0};
        n_e = '{default: '0};
        rst_n = 1'b0; flush_i = 1'b0; iq_empty_i = 1'b1; iq_instr_i = '0; iq_id_i = '0;
        iq_rs1_i = '0; iq_rs2_i = '0; issue_ready_i = 1'b0; wb_valid_i = 1'b0; wb_vd_i = '0;

        // Reset values
        #7;
        chk("rst_pop", 32'(iq_pop_o), 32'd0);
        chk("rst_valid", 32'(issue_valid_o), 32'd0);
        chk("rst_err", 32'(err_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_instr", issue_instr_o, 32'd0);
        chk("rst_id", 32'(issue_id_o), 32'd0);
        chk("rst_err_id", 32'(err_id_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single instruction from an idle, clean dispatcher
        for (int i = 0; i < 7; i++) begin
            issue_ready_i = 1'b0;
            push(tbl[i].instr, tbl[i].id);
            eval();
            chk("tbl_pop", 32'(iq_pop_o), 32'd1);
            adv();
            issue_ready_i = 1'b1;
            eval();
            chk("tbl_valid", 32'(issue_valid_o), 32'(!tbl[i].is_err));
            chk("tbl_err", 32'(err_valid_o), 32'(tbl[i].is_err));
            if (tbl[i].is_err) begin
                chk("tbl_err_id", 32'(err_id_o), 32'(tbl[i].id));
            end else begin
                chk("tbl_vd", 32'(issue_vd_o), 32'(tbl[i].vd));
                chk("tbl_vs1", 32'(issue_vs1_o), 32'(tbl[i].vs1));
                chk("tbl_vs2", 32'(issue_vs2_o), 32'(tbl[i].vs2));
                chk("tbl_f3", 32'(issue_funct3_o), 32'(tbl[i].f3));
                chk("tbl_id", 32'(issue_id_o), 32'(tbl[i].id));
            end
            adv();
            issue_ready_i = 1'b0;
            eval();
            chk("tbl_busy_after", 32'(busy_o), 32'(tbl[i].busy_after));
            adv();
            do_flush();
        end

        // RAW: v4 <- v3 stalls until v3 is written back
        issue_ready_i = 1'b1;
        push(mk(3'd0, 5'd3, 5'd1, 5'd2), 4'd1);
        push(mk(3'd0, 5'd4, 5'd1, 5'd3), 4'd2);
        run(2);
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("raw_stall", 32'(issue_valid_o), 32'd0);
            adv();
        end
        wb_valid_i = 1'b1; wb_vd_i = 5'd3;
        eval();
        chk("raw_wb_cycle", 32'(issue_valid_o), 32'(BYPASS));
        adv();
        wb_valid_i = 1'b0;
        eval();
        chk("raw_after_wb", 32'(issue_valid_o), 32'(!BYPASS));
        adv();
        do_flush();

        // WAW on v7 with payload held under backpressure
        issue_ready_i = 1'b0;
        push(mk(3'd0, 5'd7, 5'd1, 5'd2), 4'd3);
        push(mk(3'd0, 5'd7, 5'd4, 5'd5), 4'd4);
        run(1);
        for (int i = 0; i < 5; i++) begin
            eval();
            chk("waw_hold_valid", 32'(issue_valid_o), 32'd1);
            chk("waw_hold_instr", issue_instr_o, mk(3'd0, 5'd7, 5'd1, 5'd2));
            chk("waw_hold_id", 32'(issue_id_o), 32'd3);
            chk("waw_hold_nopop", 32'(iq_pop_o), 32'd0);
            adv();
        end
        issue_ready_i = 1'b1;
        run(1);
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("waw_stall", 32'(issue_valid_o), 32'd0);
            chk("waw_nopop", 32'(iq_pop_o), 32'd0);
            adv();
        end
        do_flush();

        // Illegal opcode, then next entry popped during the error cycle
        push(32'h00000013, 4'd9);
        push(mk(3'd0, 5'd8, 5'd1, 5'd2), 4'd10);
        run(1);
        eval();
        chk("ill_err", 32'(err_valid_o), 32'd1);
        chk("ill_err_id", 32'(err_id_o), 32'd9);
        chk("ill_noissue", 32'(issue_valid_o), 32'd0);
        chk("ill_pop", 32'(iq_pop_o), 32'd1);
        adv();
        eval();
        chk("ill_err_clear", 32'(err_valid_o), 32'd0);
        chk("ill_next_id", 32'(issue_id_o), 32'd10);
        adv();
        do_flush();

        // OPCFG issues with the whole scoreboard busy and leaves it untouched
        for (int k = 0; k < 32; k++) push(mk(3'd0, 5'(k), 5'(k), 5'(k)), 4'(k));
        run(34);
        push(mk(3'd7, 5'd5, 5'd3, 5'd4), 4'd11);
        run(1);
        eval();
        chk("cfg_issue", 32'(issue_valid_o), 32'd1);
        adv();
        push(mk(3'd0, 5'd9, 5'd9, 5'd9), 4'd12);
        run(1);
        eval();
        chk("cfg_sb_kept", 32'(issue_valid_o), 32'd0);
        chk("cfg_busy", 32'(busy_o), 32'd1);
        adv();
        do_flush();

        // Same-cycle set and clear of v5, then flush while held
        push(mk(3'd0, 5'd5, 5'd1, 5'd2), 4'd12);
        run(1);
        wb_valid_i = 1'b1; wb_vd_i = 5'd5;
        eval();
        chk("sc_issue", 32'(issue_valid_o), 32'd1);
        adv();
        wb_valid_i = 1'b0;
        push(mk(3'd0, 5'd6, 5'd5, 5'd5), 4'd13);
        run(1);
        eval();
        chk("sc_set_wins", 32'(issue_valid_o), 32'd0);
        adv();
        push(mk(3'd0, 5'd1, 5'd2, 5'd3), 4'd14);
        flush_i = 1'b1;
        eval();
        chk("flush_nopop", 32'(iq_pop_o), 32'd0);
        adv();
        flush_i = 1'b0;
        eval();
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_novalid", 32'(issue_valid_o), 32'd0);
        adv();
        run(2);
        do_flush();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (q.size() < 3 && $urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    ri = $urandom;
                    if (ri[6:0] == 7'h57) ri[0] = 1'b0;
                end else if (r == 1) begin
                    ri = mk(3'd7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
                end else begin
                    ri = mk(3'($urandom_range(0, 6)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                end
                push(ri, 4'($urandom_range(0, 15)));
            end
            issue_ready_i = ($urandom_range(0, 9) < 7);
            wb_valid_i    = ($urandom_range(0, 2) == 0);
            wb_vd_i       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            flush_i       = ($urandom_range(0, 99) == 0);
            eval();
            adv();
        end
        flush_i = 1'b0; wb_valid_i = 1'b0; issue_ready_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
